mem_axi_wr_ctrl: RTL and testbench



---
 rtl/mem_axi_wr_ctrl.sv | 175 +++++++++++++++++
 tb/tb_mem_axi_wr_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_axi_wr_ctrl.sv
// AXI4 write slave: AW/W bursts -> single-beat RAM writes, one B per burst. Optional MEM_AXI_WR_STRB_MASK_EN masks strobes to addressed lanes.
// Latency: RAM write in the W handshake cycle; BVALID the cycle after the final beat.
// Backpressure: one burst in flight; AW is held off in WRITE/RESP, W is held off outside WRITE, RESP holds BVALID until BREADY.
module mem_axi_wr_ctrl #(
    parameter int WIDTH_CID = 4,
    parameter int WIDTH_AD  = 10,
    parameter int WIDTH_DA  = 32,
    parameter int WIDTH_DS  = WIDTH_DA / 8,
    parameter int WIDTH_DSB = $clog2(WIDTH_DS)
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [WIDTH_CID-1:0] AWID,
    input  logic [31:0]          AWADDR,
    input  logic [7:0]           AWLEN,
    input  logic [2:0]           AWSIZE,
    input  logic [1:0]           AWBURST,
    input  logic                 AWVALID,
    output logic                 AWREADY,
    input  logic [WIDTH_DA-1:0]  WDATA,
    input  logic [WIDTH_DS-1:0]  WSTRB,
    input  logic                 WLAST,
    input  logic                 WVALID,
    output logic                 WREADY,
    output logic [WIDTH_CID-1:0] BID,
    output logic [1:0]           BRESP,
    output logic                 BVALID,
    input  logic                 BREADY,
    output logic [WIDTH_AD-1:0]  MEM_WADDR,
    output logic [WIDTH_DA-1:0]  MEM_WDATA,
    output logic [WIDTH_DS-1:0]  MEM_WSTRB,
    output logic                 MEM_WEN
);

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_RESP} state_t;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    state_t               state_q;
    logic                 awready_q;
    logic                 wready_q;
    logic                 bvalid_q;
    logic [1:0]           bresp_q;
    logic [WIDTH_CID-1:0] bid_q;
    logic [31:0]          addr_q;
    logic [31:0]          addr_d;
    logic [7:0]           len_q;
    logic [7:0]           cnt_q;
    logic [2:0]           size_q;
    logic [1:0]           burst_q;
    logic                 err_q;
    logic                 wen_dis_q;

    logic                 w_hs;
    logic                 last_beat;
    logic                 beat_err;
    logic [31:0]          beat_bytes;
    logic [31:0]          wrap_mask;
    logic [31:0]          addr_inc;
    logic                 wrap_len_ok;
    logic                 aw_size_err;
    logic                 aw_burst_err;
    logic [1:0]           aw_burst_eff;

    assign w_hs      = WVALID & wready_q;
    assign last_beat = (cnt_q == len_q);
    assign beat_err  = (WLAST != last_beat);

    // Unsupported burst types degrade to INCR so the burst still completes; only the response flags it.
    always_comb begin
        wrap_len_ok  = (AWLEN == 8'd1) || (AWLEN == 8'd3) || (AWLEN == 8'd7) || (AWLEN == 8'd15);
        aw_size_err  = (AWSIZE > 3'(WIDTH_DSB));
        aw_burst_err = (AWBURST == 2'b11) || ((AWBURST == BURST_WRAP) && !wrap_len_ok);
        aw_burst_eff = aw_burst_err ? BURST_INCR : AWBURST;
    end

    always_comb begin
        beat_bytes = 32'd1 << size_q;
        wrap_mask  = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
        addr_inc   = addr_q + beat_bytes;
        case (burst_q)
            BURST_FIXED: addr_d = addr_q;
            BURST_WRAP:  addr_d = (addr_q & ~wrap_mask) | (addr_inc & wrap_mask);
            default:     addr_d = addr_inc;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q   <= S_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= 2'b00;
            bid_q     <= '0;
            addr_q    <= '0;
            len_q     <= '0;
            cnt_q     <= '0;
            size_q    <= '0;
            burst_q   <= '0;
            err_q     <= 1'b0;
            wen_dis_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    awready_q <= 1'b1;
                    if (AWVALID && awready_q) begin
                        awready_q <= 1'b0;
                        wready_q  <= 1'b1;
                        state_q   <= S_WRITE;
                        bid_q     <= AWID;
                        addr_q    <= AWADDR;
                        len_q     <= AWLEN;
                        size_q    <= AWSIZE;
                        burst_q   <= aw_burst_eff;
                        cnt_q     <= '0;
                        err_q     <= aw_size_err | aw_burst_err;
                        wen_dis_q <= aw_size_err;
                    end
                end
                S_WRITE: begin
                    if (w_hs) begin
                        addr_q <= addr_d;
                        cnt_q  <= cnt_q + 8'd1;
                        err_q  <= err_q | beat_err;
                        if (last_beat) begin
                            wready_q <= 1'b0;
                            bvalid_q <= 1'b1;
                            bresp_q  <= (err_q | beat_err) ? 2'b10 : 2'b00;
                            state_q  <= S_RESP;
                        end
                    end
                end
                S_RESP: begin
                    if (BREADY) begin
                        bvalid_q  <= 1'b0;
                        awready_q <= 1'b1;
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign AWREADY   = awready_q;
    assign WREADY    = wready_q;
    assign BVALID    = bvalid_q;
    assign BRESP     = bresp_q;
    assign BID       = bid_q;
    assign MEM_WEN   = w_hs & ~wen_dis_q;
    assign MEM_WADDR = addr_q[WIDTH_AD-1:0];
    assign MEM_WDATA = WDATA;

`ifdef MEM_AXI_WR_STRB_MASK_EN
    logic [31:0]         lane_base;
    logic [WIDTH_DS-1:0] lane_mask;

    // Enable only the lanes covered by this beat's aligned transfer.
    always_comb begin
        lane_base = {{(32-WIDTH_DSB){1'b0}}, addr_q[WIDTH_DSB-1:0]} & ~(beat_bytes - 32'd1);
        lane_mask = '0;
        for (int i = 0; i < WIDTH_DS; i++) begin
            lane_mask[i] = (32'(i) >= lane_base) && (32'(i) < lane_base + beat_bytes);
        end
    end

    assign MEM_WSTRB = WSTRB & lane_mask;
`else
    assign MEM_WSTRB = WSTRB;
`endif

endmodule

// File: tb/tb_mem_axi_wr_ctrl.sv
// Directed bench for mem_axi_wr_ctrl with a byte-wide RAM model on the write port.
module tb_mem_axi_wr_ctrl;

    logic        CLK;
    logic        RESET;
    logic [3:0]  AWID;
    logic [31:0] AWADDR;
    logic [7:0]  AWLEN;
    logic [2:0]  AWSIZE;
    logic [1:0]  AWBURST;
    logic        AWVALID;
    logic        AWREADY;
    logic [31:0] WDATA;
    logic [3:0]  WSTRB;
    logic        WLAST;
    logic        WVALID;
    logic        WREADY;
    logic [3:0]  BID;
    logic [1:0]  BRESP;
    logic        BVALID;
    logic        BREADY;
    logic [9:0]  MEM_WADDR;
    logic [31:0] MEM_WDATA;
    logic [3:0]  MEM_WSTRB;
    logic        MEM_WEN;

    mem_axi_wr_ctrl #(
        .WIDTH_CID(4), .WIDTH_AD(10), .WIDTH_DA(32)
    ) dut (
        .CLK(CLK), .RESET(RESET),
        .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
        .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
        .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .MEM_WADDR(MEM_WADDR), .MEM_WDATA(MEM_WDATA), .MEM_WSTRB(MEM_WSTRB), .MEM_WEN(MEM_WEN)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic [7:0] ram [0:1023];
    always @(posedge CLK) begin
        if (MEM_WEN) begin
            for (int i = 0; i < 4; i++) begin
                if (MEM_WSTRB[i]) ram[{MEM_WADDR[9:2], 2'b00} + i] <= MEM_WDATA[8*i +: 8];
            end
        end
    end

    function automatic logic [31:0] rd32(input int a);
        return {ram[a+3], ram[a+2], ram[a+1], ram[a]};
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    logic [31:0] obs_addr [16];
    logic        obs_wen  [16];
    logic [3:0]  obs_strb [16];

    task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                             input logic [2:0] size, input logic [1:0] burst, input logic [31:0] dbase,
                             input logic [3:0] strb, input bit early_last, input bit gaps, input int stop);
        int to;
        AWID = id; AWADDR = addr; AWLEN = len; AWSIZE = size; AWBURST = burst; AWVALID = 1'b1;
        to = 0;
        while (!AWREADY && to < 50) begin @(posedge CLK); #1; to++; end
        check_val("aw_accept", {31'd0, AWREADY}, 32'd1);
        @(posedge CLK); #1;
        AWVALID = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            if (stop >= 0 && i >= stop) break;
            if (gaps) begin
                repeat ((i % 2) + 1) begin
                    WVALID = 1'b0; #1;
                    check_val("gap_wen", {31'd0, MEM_WEN}, 32'd0);
                    @(posedge CLK); #1;
                end
            end
            WVALID = 1'b1; WDATA = dbase + 32'(i); WSTRB = strb;
            WLAST = (i == int'(len)) || (early_last && i == 1);
            to = 0;
            while (!WREADY && to < 50) begin @(posedge CLK); #1; to++; end
            check_val("w_accept", {31'd0, WREADY}, 32'd1);
            #1;
            obs_addr[i] = {22'd0, MEM_WADDR};
            obs_wen[i]  = MEM_WEN;
            obs_strb[i] = MEM_WSTRB;
            @(posedge CLK); #1;
        end
        WVALID = 1'b0; WLAST = 1'b0;
    endtask

    task automatic get_b(input int dly, output logic [1:0] resp, output logic [3:0] id, output int held);
        check_val("bvalid_rise", {31'd0, BVALID}, 32'd1);
        held = 0; BREADY = 1'b0;
        repeat (dly) begin
            if (BVALID) held++;
            @(posedge CLK); #1;
        end
        BREADY = 1'b1; #1;
        resp = BRESP; id = BID;
        @(posedge CLK); #1;
        BREADY = 1'b0;
        check_val("bvalid_drop", {31'd0, BVALID}, 32'd0);
        check_val("awready_after_b", {31'd0, AWREADY}, 32'd1);
    endtask

    logic [31:0] exp_wrap [4];
    logic [1:0]  resp;
    logic [3:0]  bid;
    int          held;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        RESET = 1'b1; AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
        WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_val("rst_awready", {31'd0, AWREADY}, 32'd0);
        check_val("rst_wready",  {31'd0, WREADY},  32'd0);
        check_val("rst_bvalid",  {31'd0, BVALID},  32'd0);
        check_val("rst_bresp",   {30'd0, BRESP},   32'd0);
        check_val("rst_bid",     {28'd0, BID},     32'd0);
        check_val("rst_wen",     {31'd0, MEM_WEN}, 32'd0);
        RESET = 1'b0;
        @(posedge CLK); #1;
        check_val("awready_first", {31'd0, AWREADY}, 32'd1);

        // INCR, four words
        run_burst(4'd5, 32'h10, 8'd3, 3'd2, 2'b01, 32'hA0, 4'hF, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) begin
            check_val("incr_addr", obs_addr[i], 32'h10 + 32'(4*i));
            check_val("incr_wen", {31'd0, obs_wen[i]}, 32'd1);
        end
        get_b(0, resp, bid, held);
        check_val("incr_bresp", {30'd0, resp}, 32'd0);
        check_val("incr_bid", {28'd0, bid}, 32'd5);
        for (int i = 0; i < 4; i++) check_val("incr_ram", rd32(16 + 4*i), 32'hA0 + 32'(i));

        // WRAP at 0x38
        exp_wrap = '{32'h38, 32'h3C, 32'h30, 32'h34};
        run_burst(4'd1, 32'h38, 8'd3, 3'd2, 2'b10, 32'hC0, 4'hF, 1'b0, 1'b0, -1);
        for (int i = 0; i < 4; i++) check_val("wrap_addr", obs_addr[i], exp_wrap[i]);
        get_b(0, resp, bid, held);
        check_val("wrap_bresp", {30'd0, resp}, 32'd0);

        // FIXED, three writes to one word
        run_burst(4'd2, 32'h20, 8'd2, 3'd2, 2'b00, 32'd1, 4'hF, 1'b0, 1'b0, -1);
        for (int i = 0; i < 3; i++) check_val("fixed_addr", obs_addr[i], 32'h20);
        get_b(0, resp, bid, held);
        check_val("fixed_bresp", {30'd0, resp}, 32'd0);
        check_val("fixed_ram", rd32(32'h20), 32'd3);

        // Early WLAST: burst still runs its full length, then SLVERR
        run_burst(4'd3, 32'h50, 8'd3, 3'd2, 2'b01, 32'h50, 4'hF, 1'b1, 1'b0, -1);
        check_val("elast_wen3", {31'd0, obs_wen[3]}, 32'd1);
        get_b(0, resp, bid, held);
        check_val("elast_bresp", {30'd0, resp}, 32'd2);
        check_val("elast_ram", rd32(32'h5C), 32'h53);
        run_burst(4'd3, 32'h50, 8'd0, 3'd2, 2'b01, 32'h77, 4'hF, 1'b0, 1'b0, -1);
        get_b(0, resp, bid, held);
        check_val("after_err_bresp", {30'd0, resp}, 32'd0);

        // W gaps and held-off BREADY
        run_burst(4'd4, 32'h60, 8'd3, 3'd2, 2'b01, 32'h60, 4'hF, 1'b0, 1'b1, -1);
        check_val("gaps_addr3", obs_addr[3], 32'h6C);
        get_b(5, resp, bid, held);
        check_val("bvalid_held", 32'(held), 32'd5);
        check_val("gaps_bresp", {30'd0, resp}, 32'd0);

        // AWBURST=11 behaves as INCR with SLVERR
        run_burst(4'd6, 32'h70, 8'd1, 3'd2, 2'b11, 32'h70, 4'hF, 1'b0, 1'b0, -1);
        check_val("b11_addr1", obs_addr[1], 32'h74);
        get_b(0, resp, bid, held);
        check_val("b11_bresp", {30'd0, resp}, 32'd2);

        // Oversized beat: accepted but never written
        run_burst(4'd7, 32'h90, 8'd1, 3'd3, 2'b01, 32'hEE, 4'hF, 1'b0, 1'b0, -1);
        check_val("size_wen0", {31'd0, obs_wen[0]}, 32'd0);
        check_val("size_wen1", {31'd0, obs_wen[1]}, 32'd0);
        get_b(0, resp, bid, held);
        check_val("size_bresp", {30'd0, resp}, 32'd2);

        // INCR crossing the top of the RAM
        run_burst(4'd8, 32'h13FC, 8'd1, 3'd2, 2'b01, 32'hB0, 4'hF, 1'b0, 1'b0, -1);
        check_val("ramwrap_addr0", obs_addr[0], 32'h3FC);
        check_val("ramwrap_addr1", obs_addr[1], 32'h000);
        get_b(0, resp, bid, held);
        check_val("ramwrap_bresp", {30'd0, resp}, 32'd0);
        check_val("ramwrap_ram", rd32(0), 32'hB1);

        // WRAP with illegal length falls back to INCR
        run_burst(4'd9, 32'h38, 8'd2, 3'd2, 2'b10, 32'hD0, 4'hF, 1'b0, 1'b0, -1);
        check_val("badwrap_addr2", obs_addr[2], 32'h40);
        get_b(0, resp, bid, held);
        check_val("badwrap_bresp", {30'd0, resp}, 32'd2);

        // Narrow byte write into a known word
        run_burst(4'd1, 32'h40, 8'd0, 3'd2, 2'b01, 32'h11223344, 4'hF, 1'b0, 1'b0, -1);
        get_b(0, resp, bid, held);
        run_burst(4'd1, 32'h41, 8'd0, 3'd0, 2'b01, 32'hDDCCBBAA, 4'hF, 1'b0, 1'b0, -1);
        get_b(0, resp, bid, held);
        check_val("narrow_bresp", {30'd0, resp}, 32'd0);
`ifdef MEM_AXI_WR_STRB_MASK_EN
        check_val("narrow_strb", {28'd0, obs_strb[0]}, 32'h2);
        check_val("narrow_ram", rd32(32'h40), 32'h1122BB44);
`else
        check_val("narrow_strb", {28'd0, obs_strb[0]}, 32'hF);
        check_val("narrow_ram", rd32(32'h40), 32'hDDCCBBAA);
`endif

        // W offered while idle is refused
        WVALID = 1'b1; WDATA = 32'h12345678; WSTRB = 4'hF; #1;
        check_val("idle_wready", {31'd0, WREADY}, 32'd0);
        check_val("idle_wen", {31'd0, MEM_WEN}, 32'd0);
        @(posedge CLK); #1;
        check_val("idle_wready2", {31'd0, WREADY}, 32'd0);
        WVALID = 1'b0;

        // Reset in the middle of a burst
        run_burst(4'd10, 32'h80, 8'd3, 3'd2, 2'b01, 32'hC0, 4'hF, 1'b0, 1'b0, 2);
        RESET = 1'b1; #1;
        check_val("midrst_wready", {31'd0, WREADY}, 32'd0);
        check_val("midrst_awready", {31'd0, AWREADY}, 32'd0);
        check_val("midrst_bvalid", {31'd0, BVALID}, 32'd0);
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(posedge CLK); #1;
        check_val("midrst_awready_rel", {31'd0, AWREADY}, 32'd1);
        check_val("midrst_no_b", {31'd0, BVALID}, 32'd0);
        check_val("midrst_ram0", rd32(32'h80), 32'hC0);
        check_val("midrst_ram1", rd32(32'h84), 32'hC1);
        run_burst(4'd11, 32'h88, 8'd0, 3'd2, 2'b01, 32'hE0, 4'hF, 1'b0, 1'b0, -1);
        get_b(0, resp, bid, held);
        check_val("post_rst_bresp", {30'd0, resp}, 32'd0);
        check_val("post_rst_bid", {28'd0, bid}, 32'd11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
